xif_mem_bridge: RTL and testbench

Memory-side bridge directly downstream of the FPU coprocessor's CORE-V-XIF memory request/result channels. Accepts one `mem_req` transaction at a time, presents it on a simple request/grant/response data bus, and returns the matching `mem_result` with the transaction id. Misaligned accesses are rejected without a bus access. A bus-grant timeout is optional.

---
 rtl/xif_mem_bridge.sv | 151 +++++++++++++++
 tb/tb_xif_mem_bridge.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xif_mem_bridge.sv
// Bridges CORE-V-XIF mem_req/mem_result onto a req/gnt/rvalid data bus, one transaction at a time.
// Latency: 3 cycles accept-to-result minimum (aligned), 1 cycle for misaligned rejects.
// Backpressure: mem_ready is high only in IDLE; bus_req holds stable until bus_gnt.
//
// Ports:
//   ck, rst            clock, synchronous active-high reset
//   mem_valid/ready    request handshake; mem_req_* sampled only at the accept edge
//   mem_result_*       one-cycle result pulse (no ready), id/rdata/err zero outside it
//   bus_req/gnt        bus request, granted when bus_gnt is seen while bus_req is high
//   bus_addr/we/be/wdata  captured request fields, word-aligned address
//   bus_rvalid/rdata/err  bus response, only honoured while waiting for it
// Optional feature: define XMEM_TIMEOUT_EN to abort REQ after TIMEOUT_CYCLES ungranted cycles.
module xif_mem_bridge #(
   parameter int X_ID_WIDTH     = 4,
   parameter int XLEN           = 32,
   parameter int X_MEM_WIDTH    = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                     ck,
   input  logic                     rst,
   input  logic                     mem_valid,
   output logic                     mem_ready,
   input  logic [X_ID_WIDTH-1:0]    mem_req_id,
   input  logic [XLEN-1:0]          mem_req_addr,
   input  logic                     mem_req_we,
   input  logic [X_MEM_WIDTH/8-1:0] mem_req_be,
   input  logic [X_MEM_WIDTH-1:0]   mem_req_wdata,
   output logic                     mem_result_valid,
   output logic [X_ID_WIDTH-1:0]    mem_result_id,
   output logic [X_MEM_WIDTH-1:0]   mem_result_rdata,
   output logic                     mem_result_err,
   output logic                     bus_req,
   input  logic                     bus_gnt,
   output logic [XLEN-1:0]          bus_addr,
   output logic                     bus_we,
   output logic [X_MEM_WIDTH/8-1:0] bus_be,
   output logic [X_MEM_WIDTH-1:0]   bus_wdata,
   input  logic                     bus_rvalid,
   input  logic [X_MEM_WIDTH-1:0]   bus_rdata,
   input  logic                     bus_err
);

   localparam int BE_W = X_MEM_WIDTH / 8;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("xif_mem_bridge: TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t                  state;
   logic [X_ID_WIDTH-1:0]   id_q;
   // Only word-aligned requests reach the bus, so the low two address bits are never stored.
   logic [XLEN-3:0]         addr_q;
   logic                    we_q;
   logic [BE_W-1:0]         be_q;
   logic [X_MEM_WIDTH-1:0]  wdata_q;
   logic [X_MEM_WIDTH-1:0]  rdata_q;
   logic                    err_q;

`ifdef XMEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]        tmo_cnt;
`endif

   always_ff @(posedge ck) begin
      if (rst) begin
         state   <= S_IDLE;
         id_q    <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
`ifdef XMEM_TIMEOUT_EN
         tmo_cnt <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (mem_valid) begin
                  id_q    <= mem_req_id;
                  addr_q  <= mem_req_addr[XLEN-1:2];
                  we_q    <= mem_req_we;
                  be_q    <= mem_req_be;
                  wdata_q <= mem_req_wdata;
                  rdata_q <= '0;
`ifdef XMEM_TIMEOUT_EN
                  tmo_cnt <= '0;
`endif
                  // Misaligned accesses are answered straight away and never reach the bus.
                  if (mem_req_addr[1:0] != 2'b00) begin
                     err_q <= 1'b1;
                     state <= S_RESP;
                  end else begin
                     err_q <= 1'b0;
                     state <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               // A grant in the last counted cycle takes priority over the timeout.
               if (bus_gnt) begin
                  state <= S_WAIT;
               end
`ifdef XMEM_TIMEOUT_EN
               else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
                  state   <= S_RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
`endif
            end
            S_WAIT: begin
               if (bus_rvalid) begin
                  rdata_q <= (we_q || bus_err) ? '0 : bus_rdata;
                  err_q   <= bus_err;
                  state   <= S_RESP;
               end
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign mem_ready        = (state == S_IDLE);
   assign mem_result_valid = (state == S_RESP);
   assign mem_result_id    = (state == S_RESP) ? id_q    : '0;
   assign mem_result_rdata = (state == S_RESP) ? rdata_q : '0;
   assign mem_result_err   = (state == S_RESP) && err_q;

   assign bus_req   = (state == S_REQ);
   assign bus_addr  = {addr_q, 2'b00};
   assign bus_we    = we_q;
   assign bus_be    = be_q;
   assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_xif_mem_bridge.sv
// Randomised bench for xif_mem_bridge against a transaction-level expected-result model.
// Latency: checks exact result cycle, bus field stability and one result per accepted request.
// Backpressure: bench acts as the bus, choosing grant and response delays per transaction.
module tb_xif_mem_bridge;

   localparam int IDW  = 4;
   localparam int XL   = 32;
   localparam int MW   = 32;
   localparam int BW   = MW / 8;
   localparam int TMO  = 4;
`ifdef XMEM_TIMEOUT_EN
   localparam int DMAX = TMO - 1;
`else
   localparam int DMAX = 6;
`endif

   logic           ck = 1'b0;
   logic           rst;
   logic           mem_valid;
   logic           mem_ready;
   logic [IDW-1:0] mem_req_id;
   logic [XL-1:0]  mem_req_addr;
   logic           mem_req_we;
   logic [BW-1:0]  mem_req_be;
   logic [MW-1:0]  mem_req_wdata;
   logic           mem_result_valid;
   logic [IDW-1:0] mem_result_id;
   logic [MW-1:0]  mem_result_rdata;
   logic           mem_result_err;
   logic           bus_req;
   logic           bus_gnt;
   logic [XL-1:0]  bus_addr;
   logic           bus_we;
   logic [BW-1:0]  bus_be;
   logic [MW-1:0]  bus_wdata;
   logic           bus_rvalid;
   logic [MW-1:0]  bus_rdata;
   logic           bus_err;

   xif_mem_bridge #(
      .X_ID_WIDTH(IDW), .XLEN(XL), .X_MEM_WIDTH(MW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .ck(ck), .rst(rst),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_req_id(mem_req_id), .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
      .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata),
      .mem_result_valid(mem_result_valid), .mem_result_id(mem_result_id),
      .mem_result_rdata(mem_result_rdata), .mem_result_err(mem_result_err),
      .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_addr(bus_addr), .bus_we(bus_we),
      .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
   );

   always #5 ck = ~ck;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int n_res   = 0;
   int exp_res = 0;
   int res_id_q[$];
   int res_cyc_q[$];

   always @(posedge ck) cyc <= cyc + 1;

   // Independent result monitor: every pulse seen, in order, with its cycle stamp.
   always @(negedge ck) begin
      if (mem_result_valid) begin
         n_res = n_res + 1;
         res_id_q.push_back(int'(mem_result_id));
         res_cyc_q.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   typedef struct {
      logic          on_bus;
      logic          err;
      logic [MW-1:0] rdata;
   } exp_t;

   // What the coprocessor must see, straight from the access rules.
   function automatic exp_t model(input logic [XL-1:0] addr, input logic we,
                                  input logic [MW-1:0] brdata, input logic berr);
      exp_t e;
      if (addr % 4 != 0) begin
         e.on_bus = 1'b0;
         e.err    = 1'b1;
         e.rdata  = '0;
      end else begin
         e.on_bus = 1'b1;
         e.err    = berr;
         e.rdata  = (we || berr) ? '0 : brdata;
      end
      return e;
   endfunction

   // Runs one transaction from a negedge in IDLE; returns at the negedge after the result.
   // d = ungranted REQ cycles before the grant, r = WAIT cycles before rvalid.
   task automatic do_txn(input logic [IDW-1:0] id, input logic [XL-1:0] addr, input logic we,
                         input logic [BW-1:0] be, input logic [MW-1:0] wdata,
                         input int d, input int r, input logic [MW-1:0] brdata, input logic berr);
      exp_t e;
      int   n0;
      e  = model(addr, we, brdata, berr);
      n0 = n_res;
      chk("ready_idle", 64'(mem_ready), 64'(1));
      mem_valid     = 1'b1;
      mem_req_id    = id;
      mem_req_addr  = addr;
      mem_req_we    = we;
      mem_req_be    = be;
      mem_req_wdata = wdata;
      @(negedge ck);
      // Later request-side changes must not leak into the captured transaction.
      mem_valid     = 1'b0;
      mem_req_id    = IDW'($urandom);
      mem_req_addr  = $urandom;
      mem_req_we    = 1'($urandom);
      mem_req_be    = BW'($urandom);
      mem_req_wdata = $urandom;
      chk("ready_busy", 64'(mem_ready), 64'(0));
      if (!e.on_bus) begin
         chk("misal_no_req", 64'(bus_req), 64'(0));
      end else begin
         for (int i = 0; i <= d; i++) begin
            chk("req_high", 64'(bus_req), 64'(1));
            chk("bus_addr", 64'(bus_addr), 64'(addr));
            chk("bus_we_be", 64'({bus_we, bus_be}), 64'({we, be}));
            chk("bus_wdata", 64'(bus_wdata), 64'(wdata));
            bus_gnt    = (i == d);
            bus_rvalid = 1'($urandom);
            bus_rdata  = $urandom;
            bus_err    = 1'($urandom);
            @(negedge ck);
         end
         for (int j = 0; j <= r; j++) begin
            chk("req_low_wait", 64'(bus_req), 64'(0));
            chk("no_early_res", 64'(mem_result_valid), 64'(0));
            bus_gnt    = 1'($urandom);
            bus_rvalid = (j == r);
            bus_rdata  = (j == r) ? brdata : $urandom;
            bus_err    = (j == r) ? berr : 1'($urandom);
            @(negedge ck);
         end
         bus_gnt    = 1'b0;
         bus_rvalid = 1'b0;
         bus_err    = 1'b0;
      end
      chk("res_valid", 64'(mem_result_valid), 64'(1));
      chk("res_id", 64'(mem_result_id), 64'(id));
      chk("res_rdata", 64'(mem_result_rdata), 64'(e.rdata));
      chk("res_err", 64'(mem_result_err), 64'(e.err));
      exp_res++;
      @(negedge ck);
      chk("res_pulse", 64'(mem_result_valid), 64'(0));
      chk("ready_after", 64'(mem_ready), 64'(1));
      chk("one_result", 64'(n_res - n0), 64'(1));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int base;
      int nxt;
      int hi;
      logic acc_now;
      logic [XL-1:0] a;

      rst = 1'b1; mem_valid = 1'b0; mem_req_id = '0; mem_req_addr = '0; mem_req_we = 1'b0;
      mem_req_be = '0; mem_req_wdata = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
      bus_rdata = '0; bus_err = 1'b0;
      repeat (3) @(negedge ck);
      rst = 1'b0;
      @(negedge ck);

      chk("rst_ready", 64'(mem_ready), 64'(1));
      chk("rst_res_valid", 64'(mem_result_valid), 64'(0));
      chk("rst_res_err", 64'(mem_result_err), 64'(0));
      chk("rst_res_id", 64'(mem_result_id), 64'(0));
      chk("rst_res_rdata", 64'(mem_result_rdata), 64'(0));
      chk("rst_bus_req", 64'(bus_req), 64'(0));
      chk("rst_bus_addr", 64'(bus_addr), 64'(0));
      chk("rst_bus_ctl", 64'({bus_we, bus_be}), 64'(0));
      chk("rst_bus_wdata", 64'(bus_wdata), 64'(0));

      // Directed cases.
      do_txn(4'd3, 32'h100, 1'b0, 4'hF, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0);
      do_txn(4'd5, 32'h204, 1'b1, 4'hF, 32'h12345678, DMAX < 4 ? DMAX : 4, 0, 32'hCAFEF00D, 1'b0);
      do_txn(4'd7, 32'h102, 1'b0, 4'hF, 32'h0, 0, 0, 32'h11111111, 1'b0);
      do_txn(4'd9, 32'h108, 1'b0, 4'hF, 32'h0, 1, 1, 32'hFFFFFFFF, 1'b1);

      // Spurious response in IDLE must be ignored.
      base = n_res;
      bus_rvalid = 1'b1; bus_rdata = 32'h55AA55AA;
      @(negedge ck);
      bus_rvalid = 1'b0;
      @(negedge ck);
      chk("idle_rvalid_ignored", 64'(n_res - base), 64'(0));

      // Reset while waiting for the response discards the transaction.
      base = n_res;
      mem_valid = 1'b1; mem_req_id = 4'd11; mem_req_addr = 32'h300; mem_req_we = 1'b0;
      @(negedge ck);
      mem_valid = 1'b0; bus_gnt = 1'b1;
      @(negedge ck);
      bus_gnt = 1'b0;
      chk("wait_req_low", 64'(bus_req), 64'(0));
      rst = 1'b1;
      @(negedge ck);
      rst = 1'b0;
      chk("rst_mid_ready", 64'(mem_ready), 64'(1));
      chk("rst_mid_req", 64'(bus_req), 64'(0));
      bus_rvalid = 1'b1;
      @(negedge ck);
      bus_rvalid = 1'b0;
      repeat (3) @(negedge ck);
      chk("rst_mid_no_result", 64'(n_res - base), 64'(0));

      // Back-to-back with mem_valid held: instant grant and response.
      base = res_id_q.size();
      bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hA5A50001; bus_err = 1'b0;
      mem_req_addr = 32'h40; mem_req_we = 1'b0; mem_req_be = 4'hF;
      mem_req_id = 4'd1; mem_valid = 1'b1; nxt = 1;
      for (int c = 0; c < 20; c++) begin
         acc_now = mem_ready && mem_valid;
         @(posedge ck);
         #1;
         if (acc_now) begin
            nxt++;
            if (nxt > 3) mem_valid = 1'b0;
            else mem_req_id = IDW'(nxt);
         end
         @(negedge ck);
      end
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      exp_res += 3;
      chk("b2b_count", 64'(res_id_q.size() - base), 64'(3));
      for (int k = 0; k < 3 && base + k < res_id_q.size(); k++) begin
         chk("b2b_id", 64'(res_id_q[base+k]), 64'(k + 1));
         if (k > 0) chk("b2b_gap", 64'(res_cyc_q[base+k] - res_cyc_q[base+k-1]), 64'(4));
      end

`ifdef XMEM_TIMEOUT_EN
      // Never granted: bus_req for exactly TMO cycles, then an error result.
      mem_valid = 1'b1; mem_req_id = 4'd12; mem_req_addr = 32'h500; mem_req_we = 1'b0;
      @(negedge ck);
      mem_valid = 1'b0;
      hi = 0;
      for (int c = 0; c < 3 * TMO && !mem_result_valid; c++) begin
         if (bus_req) hi++;
         @(negedge ck);
      end
      chk("tmo_req_cycles", 64'(hi), 64'(TMO));
      chk("tmo_valid", 64'(mem_result_valid), 64'(1));
      chk("tmo_err", 64'(mem_result_err), 64'(1));
      chk("tmo_rdata", 64'(mem_result_rdata), 64'(0));
      chk("tmo_id", 64'(mem_result_id), 64'(12));
      exp_res++;
      @(negedge ck);
      // Grant in the last counted cycle completes normally.
      do_txn(4'd13, 32'h504, 1'b0, 4'hF, 32'h0, TMO - 1, 0, 32'h600DF00D, 1'b0);
`else
      hi = 0;
`endif

      // Randomised transactions.
      for (int t = 0; t < 40; t++) begin
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         do_txn(IDW'($urandom), a, 1'($urandom), BW'($urandom), $urandom,
                $urandom_range(0, DMAX), $urandom_range(0, 3), $urandom,
                ($urandom_range(0, 4) == 0));
      end

      repeat (2) @(negedge ck);
      chk("total_results", 64'(n_res), 64'(exp_res));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
